cmd_sequencer: RTL and testbench

//  Front-end controller for the stopwatch control FSM. Debounces three push-buttons
//  (start, pause, stop), turns presses into single-cycle commands on cmd[1:0]
//  (nop=0, start=1, pause=2, stop=3) and drives the FSM's 2-bit command input.

---
 rtl/cmd_sequencer.sv | 116 +++++++++++
 tb/tb_cmd_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer.sv
// Push-button front end for the stopwatch FSM: debounces start/pause/stop, arbitrates
// simultaneous presses (stop > pause > start) and enforces a hold-off after each command.
module cmd_sequencer #(
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_stop,
    output logic [1:0] cmd,
    output logic       busy,
    output logic       dropped
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    typedef enum logic {IDLE, HOLD} state_t;
    typedef enum logic [1:0] {CMD_NOP, CMD_START, CMD_PAUSE, CMD_STOP} cmd_t;

    // Bit order everywhere: 0 = start, 1 = pause, 2 = stop.
    logic [2:0] raw;
    assign raw = {btn_stop, btn_pause, btn_start};

    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]         db_q, db_d;
    logic [2:0]         db_dly_q, db_dly_d;
    logic [2:0]         press_q, press_d;
    state_t             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    cmd_t               cmd_q, cmd_d;
    logic               busy_q, busy_d;
    logic               dropped_q, dropped_d;

    logic any_press, multi_press;
    cmd_t winner;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cnt_d = '0;
        db_d  = db_q;
        for (int i = 0; i < 3; i++) begin
            if (raw[i] != db_q[i]) begin
                if (cnt_q[i] == DEB_LAST) db_d[i] = raw[i];
                else                      cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        // press fires the cycle after the debounced level rises; falls are ignored.
        db_dly_d = db_q;
        press_d  = db_q & ~db_dly_q;
    end

    always_comb begin
        any_press   = |press_q;
        multi_press = (press_q[0] & press_q[1]) | (press_q[0] & press_q[2]) |
                      (press_q[1] & press_q[2]);
        if (press_q[2])      winner = CMD_STOP;
        else if (press_q[1]) winner = CMD_PAUSE;
        else                 winner = CMD_START;

        state_d   = state_q;
        hold_d    = hold_q;
        cmd_d     = CMD_NOP;
        busy_d    = 1'b0;
        dropped_d = 1'b0;

        // The last hold cycle (counter at zero) behaves exactly like IDLE.
        if (state_q == HOLD && hold_q != '0) begin
            busy_d    = 1'b1;
            hold_d    = hold_q - HW'(1);
            dropped_d = any_press;
        end else if (any_press) begin
            cmd_d     = winner;
            busy_d    = 1'b1;
            dropped_d = multi_press;
            hold_d    = HOLD_LOAD;
            state_d   = HOLD;
        end else begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q     <= '0;
            db_q      <= '0;
            db_dly_q  <= '0;
            press_q   <= '0;
            state_q   <= IDLE;
            hold_q    <= '0;
            cmd_q     <= CMD_NOP;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_dly_q  <= db_dly_d;
            press_q   <= press_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            cmd_q     <= cmd_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign cmd     = cmd_q;
    assign busy    = busy_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: an edge-indexed behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized button traffic.
module tb_cmd_sequencer;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_stop = 1'b0;
    logic [1:0] cmd;
    logic       busy;
    logic       dropped;

    cmd_sequencer #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .clr      (clr),
        .btn_start(btn_start),
        .btn_pause(btn_pause),
        .btn_stop (btn_stop),
        .cmd      (cmd),
        .busy     (busy),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: debounced level, run of disagreeing samples, edge of last accepted rise,
    // and the first edge at which a new command may be accepted.
    int m_db[3];
    int m_streak[3];
    int m_rise[3];
    int m_free_at;
    int edge_no = 0;

    int e_cmd, e_busy, e_drop;
    logic [2:0] s_raw, s_p;

    int n_cmd[4];
    int last_cmd_edge[4];
    int n_drop, n_busy, last_drop_edge;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_db[i]     = 0;
            m_streak[i] = 0;
            m_rise[i]   = -100;
        end
        m_free_at = 0;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            n_cmd[i]         = 0;
            last_cmd_edge[i] = -1;
        end
        n_drop         = 0;
        n_busy         = 0;
        last_drop_edge = -1;
    endtask

    // A rise accepted at edge n reaches the arbiter as a press at edge n+2.
    always begin
        @(posedge clk);
        edge_no++;
        s_raw = {btn_stop, btn_pause, btn_start};
        if (clr) begin
            model_reset();
            e_cmd  = 0;
            e_busy = 0;
            e_drop = 0;
        end else begin
            for (int i = 0; i < 3; i++) s_p[i] = (m_rise[i] == edge_no - 2);
            if (s_p != 3'b000) begin
                if (edge_no >= m_free_at) begin
                    e_cmd     = s_p[2] ? 3 : (s_p[1] ? 2 : 1);
                    e_busy    = 1;
                    e_drop    = ($countones(s_p) > 1) ? 1 : 0;
                    m_free_at = edge_no + HOLD + 1;
                end else begin
                    e_cmd  = 0;
                    e_busy = 1;
                    e_drop = 1;
                end
            end else begin
                e_cmd  = 0;
                e_drop = 0;
                e_busy = (edge_no < m_free_at) ? 1 : 0;
            end
            for (int i = 0; i < 3; i++) begin
                if (int'(s_raw[i]) == m_db[i]) begin
                    m_streak[i] = 0;
                end else begin
                    m_streak[i]++;
                    if (m_streak[i] == DEB) begin
                        m_db[i]     = int'(s_raw[i]);
                        m_streak[i] = 0;
                        if (s_raw[i]) m_rise[i] = edge_no;
                    end
                end
            end
        end
        #1;
        check("cmd", 32'(cmd), 32'(e_cmd));
        check("busy", 32'(busy), 32'(e_busy));
        check("dropped", 32'(dropped), 32'(e_drop));
        if (cmd != 2'd0) begin
            n_cmd[cmd]++;
            last_cmd_edge[cmd] = edge_no;
        end
        if (dropped) begin
            n_drop++;
            last_drop_edge = edge_no;
        end
        if (busy) n_busy++;
    end

    task automatic set_btn(input logic [2:0] m);
        {btn_stop, btn_pause, btn_start} = m;
    endtask

    // Returns the edge number at which the just-driven inputs are first sampled.
    task automatic mark(output int k);
        @(posedge clk);
        #2;
        k = edge_no;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int k;

    initial begin
        model_reset();
        clear_stats();

        // 1: reset, then a clean start press
        clr = 1'b1;
        idle(2);
        clr = 1'b0;
        check("reset_cmd", 32'(cmd), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_dropped", 32'(dropped), 0);
        clear_stats();
        set_btn(3'b001);
        mark(k);
        idle(9);
        set_btn(3'b000);
        idle(30);
        check("t1_start_count", n_cmd[1], 1);
        check("t1_start_latency", last_cmd_edge[1] - k, 5);
        check("t1_busy_cycles", n_busy, 9);
        check("t1_dropped", n_drop, 0);

        // 2: bouncing pause never settles
        clear_stats();
        for (int i = 0; i < 12; i++) begin
            btn_pause = (i % 2 == 0);
            idle(1);
        end
        btn_pause = 1'b0;
        idle(20);
        check("t2_cmds", n_cmd[1] + n_cmd[2] + n_cmd[3], 0);
        check("t2_dropped", n_drop, 0);

        // 3: start and stop together -> stop wins, start dropped
        clear_stats();
        set_btn(3'b101);
        mark(k);
        idle(10);
        set_btn(3'b000);
        idle(30);
        check("t3_stop_count", n_cmd[3], 1);
        check("t3_start_count", n_cmd[1], 0);
        check("t3_dropped", n_drop, 1);
        check("t3_drop_same_cycle", last_drop_edge, last_cmd_edge[3]);
        check("t3_latency", last_cmd_edge[3] - k, 5);

        // 4: pause press lands inside the stop hold-off
        clear_stats();
        set_btn(3'b100);
        mark(k);
        idle(5);
        set_btn(3'b110);
        idle(10);
        set_btn(3'b000);
        idle(30);
        check("t4_stop_count", n_cmd[3], 1);
        check("t4_pause_count", n_cmd[2], 0);
        check("t4_dropped", n_drop, 1);
        check("t4_busy_cycles", n_busy, 9);
        check("t4_drop_edge", last_drop_edge - k, 10);

        // 5: clr while the start press is in flight
        clear_stats();
        set_btn(3'b001);
        mark(k);
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5_cmd_after_clr", 32'(cmd), 0);
        check("t5_busy_after_clr", 32'(busy), 0);
        check("t5_drop_after_clr", 32'(dropped), 0);
        check("t5_no_start_yet", n_cmd[1], 0);
        idle(20);
        check("t5_start_count", n_cmd[1], 1);
        check("t5_start_edge", last_cmd_edge[1] - k, 11);
        check("t5_dropped", n_drop, 0);
        set_btn(3'b000);
        idle(30);

        // 6: long hold, release, second press after hold-off
        clear_stats();
        set_btn(3'b010);
        idle(40);
        set_btn(3'b000);
        idle(30);
        set_btn(3'b010);
        idle(10);
        set_btn(3'b000);
        idle(30);
        check("t6_pause_count", n_cmd[2], 2);
        check("t6_other_cmds", n_cmd[1] + n_cmd[3], 0);
        check("t6_dropped", n_drop, 0);

        // Random traffic: bursty toggling, glitches and occasional clr
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 9) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(0, 9) == 0) btn_stop  = ~btn_stop;
            clr = ($urandom_range(0, 299) == 0);
        end
        clr = 1'b0;
        set_btn(3'b000);
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
